// File: rtl/mod_down_counter.sv
// Modulo-MAX down counter with IDLE/RUN/DONE control, one-shot or periodic reload,
// clamped synchronous preset and a registered one-cycle terminal-count pulse.
module mod_down_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  // MAX may equal 2**W, so MAX-1 is the largest value that must fit in W bits.
  if ((MAX < 2) || (MAX > (2 ** W))) begin : g_bad_param
    $error("mod_down_counter: MAX must satisfy 2 <= MAX <= 2**W");
  end

  localparam logic [W-1:0] CntMax = W'(MAX - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic [W-1:0] load_clamped;

  // Full-width compare, so no value above MAX-1 can ever be preset.
  assign load_clamped = (load_val > CntMax) ? CntMax : load_val;

  // Next-state logic; priority is stop > load > start > en.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (stop) begin
      // Pause semantics: count is kept, only the state returns to idle.
      state_d = StIdle;
    end else if (load) begin
      count_d = load_clamped;
      if (start && (state_q != StRun)) begin
        state_d = StRun;
      end
    end else if (start && (state_q != StRun)) begin
      state_d = StRun;
      count_d = CntMax;
    end else if (en && (state_q == StRun)) begin
      if (count_q == '0) begin
        // oneshot only matters here, at the terminal event.
        tc_d = 1'b1;
        if (oneshot) begin
          state_d = StDone;
        end else begin
          count_d = CntMax;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State, count and tc registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule

// File: doc/mod_down_counter.md
MOD_DOWN_COUNTER -- requirements
Module: mod_down_counter

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the count width in bits.
REQ-002 The block SHALL have parameter MAX, default 10, giving the modulus; it need not be a power of 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable (tick).
REQ-006 The block SHALL have port start, input, 1 bit: arm the counter from IDLE or DONE.
REQ-007 The block SHALL have port stop, input, 1 bit: halt the counter and return to IDLE.
REQ-008 The block SHALL have port oneshot, input, 1 bit: 1 = halt at terminal count, 0 = periodic reload.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous preset strobe.
REQ-010 The block SHALL have port load_val, input, W bits: preset value.
REQ-011 The block SHALL have port count, output, W bits: current count, driven directly from a register.
REQ-012 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-015 The block SHALL fail elaboration unless 2 <= MAX <= 2**W.
REQ-016 The state machine SHALL have exactly three states (IDLE, RUN, DONE); busy and done SHALL decode the state register with no other logic.
REQ-017 Per-cycle priority SHALL be: rst_n low > stop > load > start > en.
REQ-018 Load value SHALL be clamped: count <= (load_val > MAX-1) ? MAX-1 : load_val; the comparison SHALL be at full W-bit width with no truncation.
REQ-019 IDLE: count holds; start SHALL move to RUN with count <= MAX-1; start with load in the same cycle SHALL move to RUN with count <= clamped load_val.
REQ-020 RUN, en=1, count > 0: count SHALL decrement by exactly 1 per cycle; en=0: count holds.
REQ-021 RUN, en=1, count == 0, oneshot=0: count SHALL wrap to MAX-1, state stays RUN, tc SHALL be 1 on the next cycle only.
REQ-022 RUN, en=1, count == 0, oneshot=1: count SHALL stay 0, state SHALL go to DONE, tc SHALL be 1 on the next cycle only.
REQ-023 oneshot SHALL be sampled only in the cycle of the terminal event; changing it at any other time SHALL have no effect.
REQ-024 Load in RUN: count SHALL take the clamped value, state stays RUN, and no tc SHALL be generated that cycle even when count == 0 and en=1.
REQ-025 Load in IDLE or DONE without start SHALL update count only, with no state change.
REQ-026 stop in RUN: state SHALL go to IDLE, count holds (pause semantics), no tc; stop in DONE: state SHALL go to IDLE, count holds 0.
REQ-027 DONE: count SHALL hold 0, en SHALL be ignored, and start SHALL behave as in IDLE (REQ-019).
REQ-028 Asserting start while in RUN SHALL have no effect.
REQ-029 tc SHALL never be high for two consecutive cycles unless MAX==1-equivalent wrap conditions recur; with MAX >= 2 the minimum tc spacing SHALL be MAX cycles in periodic mode.
REQ-030 count SHALL never exceed MAX-1 in any state.

Reset
REQ-031 While rst_n is low at a rising clk edge, state SHALL become IDLE, count 0, and tc 0, so busy=0 and done=0.
REQ-032 Reset SHALL override all other inputs, including reset asserted mid-RUN; after release the block SHALL stay in IDLE until start.

Verification (W=4, MAX=10)
REQ-033 Reset, then start=1 for 1 cycle, then en=1 continuous, oneshot=0 -> count sequence 9,8,...,0,9; tc high for exactly 1 cycle after each 0->9 wrap, every 10 cycles.
REQ-034 oneshot=1, start, then en=1 -> count reaches 0; next cycle done=1, tc=1 for 1 cycle, count stays 0 with en held high; start again -> count=9, busy=1.
REQ-035 In IDLE, load=1 with load_val=15 -> count=9 (clamped); load_val=4 with start -> RUN, count=4, sequence 3,2,1,0.
REQ-036 RUN at count=0 with en=1, load=1 and load_val=6 in the same cycle -> count=6, no tc pulse, stays RUN.
REQ-037 RUN at count=5, stop=1 -> IDLE, count=5 held with en high; start -> count=9 (reload, not resume).
REQ-038 rst_n low for 1 cycle mid-RUN at count=3 -> count=0, busy=0, tc=0 next cycle; en alone afterwards leaves count=0.
